// File: rtl/imem_responder.sv
// imem_responder: responder end of the core's memory interface.
// Word-organised synchronous RAM, zero-cleared by an init FSM after reset,
// with a READ_LATENCY-deep read pipeline (1..4). DEPTH_WORDS must be a
// power of 2 and ADDR_W >= log2(DEPTH_WORDS)+2.
// Optional build macro IMEM_RESPONDER_WR_FWD_EN: a read launched in the same
// cycle as a committed write to the same word returns the new data instead
// of the old contents.
module imem_responder #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wren,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  output logic              wr_err,
  output logic              ready
);

  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam int SPAN_W = IDX_W + 2;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic                  wr_err_q, wr_err_d;
  logic [READ_LATENCY:1] vld_q, vld_d;
  logic [READ_LATENCY:1] err_q, err_d;
  logic [READ_LATENCY:1] oor_q, oor_d;
  logic [DATA_W-1:0]     data_q [1:READ_LATENCY];
  logic [DATA_W-1:0]     mem [DEPTH_WORDS];

  logic                  rd_in_range, rd_misal, wr_in_range, wr_misal;
  logic [IDX_W-1:0]      rd_idx, wr_idx;
  logic                  launch, wr_ok, fwd_hit;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_widx;
  logic [DATA_W-1:0]     mem_wdata;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    if (ADDR_W <= SPAN_W) return 1'b1;
    return (addr >> SPAN_W) == '0;
  endfunction

  function automatic logic addr_misaligned(input logic [ADDR_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    return addr[2 +: IDX_W];
  endfunction

  // Address decode, write qualification, RAM write port and forwarding select
  always_comb begin
    rd_in_range = addr_in_range(rd_addr);
    rd_misal    = addr_misaligned(rd_addr);
    wr_in_range = addr_in_range(wr_addr);
    wr_misal    = addr_misaligned(wr_addr);
    rd_idx      = word_idx(rd_addr);
    wr_idx      = word_idx(wr_addr);
    launch      = (state_q == S_READY);
    wr_ok       = launch && wren && wr_in_range && !wr_misal;
    mem_we      = 1'b0;
    mem_widx    = '0;
    mem_wdata   = '0;
    if (!rst) begin
      if (state_q == S_CLEAR) begin
        mem_we   = 1'b1;
        mem_widx = cnt_q;
      end else if (wr_ok) begin
        mem_we    = 1'b1;
        mem_widx  = wr_idx;
        mem_wdata = wr_data;
      end
    end
`ifdef IMEM_RESPONDER_WR_FWD_EN
    fwd_hit = wr_ok && !rst && (wr_idx == rd_idx);
`else
    fwd_hit = 1'b0;
`endif
  end

  // Next state for the init FSM, write-error pulse and read-control pipeline
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_err_d = 1'b0;
    vld_d    = '0;
    err_d    = '0;
    oor_d    = '0;
    case (state_q)
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(DEPTH_WORDS - 1)) state_d = S_READY;
      end
      S_READY: begin
        wr_err_d = wren && !(wr_in_range && !wr_misal);
      end
      default: state_d = S_CLEAR;
    endcase
    vld_d[1] = launch;
    err_d[1] = rd_misal || !rd_in_range;
    oor_d[1] = !rd_in_range;
    for (int k = 2; k <= READ_LATENCY; k++) begin
      vld_d[k] = vld_q[k-1];
      err_d[k] = err_q[k-1];
      oor_d[k] = oor_q[k-1];
    end
  end

  // Control registers with synchronous reset; reset flushes the read pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_CLEAR;
      cnt_q    <= '0;
      wr_err_q <= 1'b0;
      vld_q    <= '0;
      err_q    <= '0;
      oor_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_err_q <= wr_err_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
      oor_q    <= oor_d;
    end
  end

  // RAM array and read-data pipeline; data path carries no reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
    data_q[1] <= fwd_hit ? wr_data : mem[rd_idx];
    for (int k = 2; k <= READ_LATENCY; k++) data_q[k] <= data_q[k-1];
  end

  // Out-of-range and idle slots present zero data
  always_comb begin
    rd_valid = vld_q[READ_LATENCY];
    rd_err   = vld_q[READ_LATENCY] && err_q[READ_LATENCY];
    rd_data  = (vld_q[READ_LATENCY] && !oor_q[READ_LATENCY]) ? data_q[READ_LATENCY] : '0;
    wr_err   = wr_err_q;
    ready    = (state_q == S_READY);
  end

endmodule

// File: tb/tb_imem_responder.sv
// Testbench for imem_responder (DEPTH_WORDS=16, READ_LATENCY=2).
// Directed test-plan scenarios plus a randomized phase, all checked every
// cycle against a behavioural model; directed points also use literal values.
module tb_imem_responder;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int RL     = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wren;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid, rd_err, wr_err, ready;

  int checks   = 0;
  int failures = 0;

  imem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_WORDS(DEPTH), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .wr_addr(wr_addr),
    .wr_data(wr_data), .wren(wren), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_err(rd_err), .wr_err(wr_err), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          vld;
    logic [31:0] data;
    bit          err;
  } ent_t;

  ent_t        pipe[$];
  logic [31:0] mmem [DEPTH];
  bit          model_on = 0;
  bit          m_ready  = 0;
  int          clr_n    = 0;
  bit          exp_wr_err = 0;
  bit          fwd_en;

  initial begin
`ifdef IMEM_RESPONDER_WR_FWD_EN
    fwd_en = 1;
`else
    fwd_en = 0;
`endif
  end

  always @(posedge clk) begin
    ent_t e;
    bit   wok;
    e.vld = 0; e.data = 0; e.err = 0;
    if (rst) begin
      model_on   = 1;
      m_ready    = 0;
      clr_n      = 0;
      exp_wr_err = 0;
      pipe.delete();
      for (int i = 0; i < RL; i++) pipe.push_back(e);
    end else if (model_on) begin
      if (!m_ready) begin
        exp_wr_err = 0;
        clr_n++;
        if (clr_n == DEPTH) begin
          for (int i = 0; i < DEPTH; i++) mmem[i] = 0;
          m_ready = 1;
        end
      end else begin
        e.vld = 1;
        if (rd_addr >= 4 * DEPTH) begin
          e.data = 0;
          e.err  = 1;
        end else begin
          e.data = mmem[rd_addr / 4];
          e.err  = (rd_addr % 4) != 0;
        end
        wok = wren && (wr_addr < 4 * DEPTH) && (wr_addr % 4 == 0);
        if (fwd_en && wok && (rd_addr < 4 * DEPTH) && (wr_addr / 4 == rd_addr / 4))
          e.data = wr_data;
        if (wok) mmem[wr_addr / 4] = wr_data;
        exp_wr_err = wren && !wok;
      end
      pipe.push_back(e);
      void'(pipe.pop_front());
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (model_on && pipe.size() == RL) begin
      chk("cyc_ready", ready, m_ready);
      chk("cyc_wr_err", wr_err, exp_wr_err);
      chk("cyc_rd_valid", rd_valid, pipe[0].vld);
      if (pipe[0].vld) begin
        chk("cyc_rd_data", rd_data, pipe[0].data);
        chk("cyc_rd_err", rd_err, pipe[0].err);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [31:0] exp_fwd;
    rst = 1; rd_addr = 0; wr_addr = 0; wr_data = 0; wren = 0;
    cyc(); cyc();
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_err", rd_err, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_ready", ready, 0);

    rst = 0; rd_addr = 32'h20;
    n = 0;
    while (!ready && n < 100) begin cyc(); n++; end
    chk("clear_cycles", n, 16);
    n = 0;
    while (!rd_valid && n < 20) begin cyc(); n++; end
    chk("first_valid_latency", n, RL);
    chk("read_0x20_data", rd_data, 0);
    chk("read_0x20_err", rd_err, 0);

    wr_addr = 32'h8; wr_data = 32'hDEADBEEF; wren = 1;
    cyc();
    wren = 0; rd_addr = 32'h8;
    cyc(); cyc();
    chk("rd8_data", rd_data, 32'hDEADBEEF);
    chk("rd8_valid", rd_valid, 1);
    chk("rd8_err", rd_err, 0);

    rd_addr = 32'hA;
    cyc(); cyc();
    chk("rdA_data", rd_data, 32'hDEADBEEF);
    chk("rdA_err", rd_err, 1);

    rd_addr = 32'h40;
    cyc(); cyc();
    chk("rd40_data", rd_data, 0);
    chk("rd40_err", rd_err, 1);

    wr_addr = 32'h40; wr_data = 32'hFFFF_FFFF; wren = 1; rd_addr = 32'h0;
    cyc();
    chk("wr40_wr_err", wr_err, 1);
    wren = 0;
    cyc();
    chk("wr40_wr_err_clear", wr_err, 0);
    chk("word0_unchanged", rd_data, 0);

    wr_addr = 32'h4; wr_data = 32'h12345678; wren = 1; rd_addr = 32'h4;
    exp_fwd = fwd_en ? 32'h12345678 : 32'h0;
    cyc();
    wren = 0;
    cyc();
    chk("same_cycle_rdw", rd_data, exp_fwd);
    cyc();
    chk("next_cycle_rd4", rd_data, 32'h12345678);

    for (int i = 0; i < 1500; i++) begin
      rd_addr = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 71) : $urandom;
      wr_addr = ($urandom_range(0, 3) == 0) ? rd_addr :
                (($urandom_range(0, 9) < 8) ? $urandom_range(0, 71) : $urandom);
      wr_data = $urandom;
      wren    = ($urandom_range(0, 9) < 4);
      cyc();
    end
    wren = 0;

    wr_addr = 32'h8; wr_data = 32'hCAFEF00D; wren = 1;
    cyc();
    wren = 0; rd_addr = 32'h8;
    cyc(); cyc(); cyc();
    chk("stream_rd8", rd_data, 32'hCAFEF00D);
    rst = 1;
    cyc();
    rst = 0;
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_ready", ready, 0);
    n = 0;
    while (!ready && n < 100) begin cyc(); n++; end
    chk("reclear_cycles", n, 16);
    n = 0;
    while (!rd_valid && n < 20) begin cyc(); n++; end
    chk("reclear_valid_latency", n, RL);
    chk("reclear_rd8", rd_data, 0);

    cyc(); cyc(); cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
